eth_reset_sequencer: RTL
========================

// Module: eth_reset_sequencer
// PURPOSE
//  Parametrised reset synchroniser and sequencer for the clk250_i domain of the ethernet controller.
//  Synchronises the async reset and releases num_rst_p downstream resets in index order
//    (e.g. IDELAY/IO -> RGMII -> MAC), with programmable spacing.
//  Holds off release until the IDELAY-ready input is high.
//  Re-runs the full sequence on a ready drop or a software reset request.
// PARAMETERS
//  sync_stages_p  4   reset synchroniser depth; must be >= 2
//  num_rst_p      3   number of sequenced reset outputs; must be >= 1
//  min_assert_p   8   minimum clk250 cycles all outputs stay asserted; must be >= 1
//  hold_cycles_p  16  clk250 cycles between successive output releases; must be >= 1
//  wait_rdy_p     1   1: gate release on rdy_i and restart on rdy_i fall; 0: ignore rdy_i
// PORTS
//  clk250_i     in   1          250 MHz clock
//  reset_r_lo   in   1          reset: asynchronous assert, active-high
//  rdy_i        in   1          IDELAY ready, asynchronous level
//  sw_reset_i   in   1          software reset request, asynchronous level; rising edge restarts
//  reset_o      out  num_rst_p  sequenced resets, active-high, registered; bit 0 released first
//  done_o       out  1          all reset_o released, registered
// BEHAVIOUR
//  Reset and clocking
//  - Reset is reset_r_lo, asynchronous, active-high; clock is clk250_i.
//  - Every flop in the block is async-set or async-cleared by reset_r_lo.
//  Reset synchroniser
//  - sync_r[sync_stages_p-1:0] is set to all-1 by reset_r_lo.
//  - Each edge shifts a 0 in at the MSB; rst_sync = sync_r[0].
//  - rst_sync therefore deasserts on the sync_stages_p-th edge after reset_r_lo falls.
//  - Mark sync_r ASYNC_REG and no shift-register extraction.
//  Input synchronisers
//  - rdy_i and sw_reset_i each pass through a 2-flop synchroniser, reset value 0.
//  - sw_edge = sw_sync & ~sw_sync_d (1-cycle pulse). With wait_rdy_p=0, rdy_ok is tied to 1.
//  Output reset values: reset_o = all 1, done_o = 0.
//  Internal counters
//  - cnt is $clog2(max(min_assert_p, hold_cycles_p)+1) bits; it saturates and never wraps.
//  - idx is $clog2(num_rst_p+1) bits.
//  FSM states: ASSERT, WAIT_RDY, RELEASE, DONE. While rst_sync=1: state=ASSERT, cnt=0, idx=0.
//  - ASSERT: reset_o all 1, cnt increments. At cnt==min_assert_p-1: go to WAIT_RDY, cnt=0.
//  - WAIT_RDY: remain until rdy_ok=1, then go to RELEASE with cnt=0. Minimum stay is 1 cycle.
//  - RELEASE: cnt increments. At cnt==hold_cycles_p-1: reset_o[idx]<=0, cnt=0, idx++.
//      When the bit released is idx==num_rst_p-1, go to DONE and set done_o<=1 on the same edge.
//  - DONE: hold. reset_o all 0, done_o=1.
//  Restart
//  - Trigger: sw_edge, or (wait_rdy_p & ~rdy_ok), in WAIT_RDY (sw_edge only), RELEASE or DONE.
//  - Next edge: state=ASSERT, reset_o all 1, done_o=0, cnt=0, idx=0.
//  - Repeated sw_edge while already in ASSERT: cnt restarts at 0, which stretches the assert.
//  Priority: rst_sync > restart > release step. A restart coinciding with a release step releases nothing.
//  Invariants
//  - reset_o is thermometer-ordered: bit i+1 is never 0 while bit i is 1.
//  - done_o == ~|reset_o at all times.
//  Timing (defaults, rdy_i high and stable)
//  - reset_o[0] falls on edge 29 after reset_r_lo falls (4 + 8 + 1 + 16).
//  - reset_o[1] falls on edge 45; reset_o[2] and done_o change on edge 61.
//  Mid-sequence reset: reset_r_lo high at any time forces the output reset values asynchronously.
// TESTING
//  T1 defaults, rdy_i=1, drop reset_r_lo -> reset_o 3'b111 -> 3'b110 @edge29, 3'b100 @45, 3'b000 + done_o=1 @61.
//  T2 rdy_i=0 for 100 cycles after reset, then 1 -> reset_o[0] falls 2 (sync) + 1 + 16 edges after rdy_i rises, not before.
//  T3 in DONE, pulse sw_reset_i for 3 cycles -> reset_o=3'b111 and done_o=0 within 4 edges; sequence repeats with 8/1/16 spacing.
//  T4 rdy_i drops while reset_o=3'b110 -> all reasserted; no bit releases until rdy_i returns.
//  T5 assert reset_r_lo mid-RELEASE for a sub-cycle glitch -> outputs 1 immediately (async); full sequence reruns from sync.
//  T6 sweep num_rst_p=1/5, hold_cycles_p=1, wait_rdy_p=0, sync_stages_p=2 -> thermometer order and done_o==~|reset_o checked every cycle.

Source files
------------

// File: rtl/eth_reset_sequencer.sv
`timescale 1ns/1ps
// eth_reset_sequencer
// Reset synchroniser and sequencer for the clk250 domain of the ethernet controller.
// The downstream resets are released in index order (IO/IDELAY -> RGMII -> MAC) with
// programmable spacing. Release waits for IDELAY ready. A ready drop or a software
// reset request restarts the whole sequence.
module eth_reset_sequencer #(
    parameter int sync_stages_p = 4,
    parameter int num_rst_p     = 3,
    parameter int min_assert_p  = 8,
    parameter int hold_cycles_p = 16,
    parameter bit wait_rdy_p    = 1'b1
) (
    input  logic                 clk250_i,
    input  logic                 reset_r_lo,
    input  logic                 rdy_i,
    input  logic                 sw_reset_i,
    output logic [num_rst_p-1:0] reset_o,
    output logic                 done_o
);

    localparam int cnt_max_lp = (min_assert_p > hold_cycles_p) ? min_assert_p : hold_cycles_p;
    localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1);
    localparam int idx_w_lp   = $clog2(num_rst_p + 1);

    localparam logic [cnt_w_lp-1:0] assert_last_lp = cnt_w_lp'(min_assert_p - 1);
    localparam logic [cnt_w_lp-1:0] hold_last_lp   = cnt_w_lp'(hold_cycles_p - 1);
    localparam logic [idx_w_lp-1:0] idx_last_lp    = idx_w_lp'(num_rst_p - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT_RDY,
        ST_RELEASE,
        ST_DONE
    } state_t;

    // Reset synchroniser chain: all ones on reset, zeros shift in from the MSB.
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [sync_stages_p-1:0] sync_r;

    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic rdy_meta_reg, rdy_sync_reg;

    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic sw_meta_reg, sw_sync_reg;

    logic sw_sync_d_reg;

    logic rst_sync;
    logic rdy_ok;
    logic sw_edge;
    logic restart;
    logic release_step;

    state_t                state_reg, state_next;
    logic [cnt_w_lp-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic [idx_w_lp-1:0]   idx_reg, idx_next;
    logic [num_rst_p-1:0]  reset_next;
    logic                  done_next;
    logic [num_rst_p-1:0]  clr_vec;

    // Shift the release chain; rst_sync stays high for sync_stages_p edges after reset falls.
    always_ff @(posedge clk250_i or posedge reset_r_lo) begin
        if (reset_r_lo) begin
            sync_r <= '1;
        end else begin
            sync_r <= {1'b0, sync_r[sync_stages_p-1:1]};
        end
    end

    assign rst_sync = sync_r[0];

    // Two-flop synchronisers for the asynchronous ready and software request levels.
    always_ff @(posedge clk250_i or posedge reset_r_lo) begin
        if (reset_r_lo) begin
            rdy_meta_reg  <= 1'b0;
            rdy_sync_reg  <= 1'b0;
            sw_meta_reg   <= 1'b0;
            sw_sync_reg   <= 1'b0;
            sw_sync_d_reg <= 1'b0;
        end else begin
            rdy_meta_reg  <= rdy_i;
            rdy_sync_reg  <= rdy_meta_reg;
            sw_meta_reg   <= sw_reset_i;
            sw_sync_reg   <= sw_meta_reg;
            sw_sync_d_reg <= sw_sync_reg;
        end
    end

    // With ready gating disabled the ready input is treated as permanently high.
    assign rdy_ok  = rdy_sync_reg | ~wait_rdy_p;
    assign sw_edge = sw_sync_reg & ~sw_sync_d_reg;

    // A software edge restarts from any state (in ASSERT it just stretches the assert);
    // a ready drop only matters once release has begun.
    assign restart = sw_edge
                   | (~rdy_ok & ((state_reg == ST_RELEASE) | (state_reg == ST_DONE)));

    assign release_step = ~rst_sync & ~restart
                        & (state_reg == ST_RELEASE) & (cnt_reg == hold_last_lp);

    // Saturating increment so the counter can never wrap back into a match.
    assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + cnt_w_lp'(1);

    // One clear strobe per output; only the bit at the current index can drop,
    // which keeps the outputs thermometer-ordered.
    generate
        for (genvar gi = 0; gi < num_rst_p; gi++) begin : g_clr
            assign clr_vec[gi] = release_step & (idx_reg == idx_w_lp'(gi));
        end
    endgenerate

    // Next-state and output decode; synchroniser reset beats restart beats release.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        reset_next = reset_o;
        done_next  = done_o;
        if (rst_sync || restart) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
            idx_next   = '0;
            reset_next = '1;
            done_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_ASSERT: begin
                    reset_next = '1;
                    done_next  = 1'b0;
                    if (cnt_reg == assert_last_lp) begin
                        state_next = ST_WAIT_RDY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                ST_WAIT_RDY: begin
                    if (rdy_ok) begin
                        state_next = ST_RELEASE;
                        cnt_next   = '0;
                    end
                end
                ST_RELEASE: begin
                    if (release_step) begin
                        reset_next = reset_o & ~clr_vec;
                        cnt_next   = '0;
                        idx_next   = idx_reg + idx_w_lp'(1);
                        if (idx_reg == idx_last_lp) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                ST_DONE: begin
                    reset_next = '0;
                    done_next  = 1'b1;
                end
                default: begin
                    state_next = ST_ASSERT;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs; the async reset forces the safe values.
    always_ff @(posedge clk250_i or posedge reset_r_lo) begin
        if (reset_r_lo) begin
            state_reg <= ST_ASSERT;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            reset_o   <= '1;
            done_o    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            reset_o   <= reset_next;
            done_o    <= done_next;
        end
    end

endmodule
